// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole spawner and detector.
// Holds the FSM state enum, LFSR taps, default mole count and onehot type.
package mole_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GAP,
      SHOW
   } spawn_state_t;

   // Galois mask for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int N_MOLES_DEF = 10;

   typedef logic [N_MOLES_DEF-1:0] onehot_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/mole_spawner_if.sv
// Link between the mole spawner (master) and the mole detector (slave).
// Carries: active_onehot, led_toggle (to detector); hit_pulse, miss_pulse (back).
interface mole_spawner_if
   import mole_pkg::*;
#(
   parameter int N_MOLES = N_MOLES_DEF
);

   logic [N_MOLES-1:0] active_onehot;
   logic               led_toggle;
   logic               hit_pulse;
   logic               miss_pulse;

   modport master (
      output active_onehot,
      output led_toggle,
      input  hit_pulse,
      input  miss_pulse
   );

   modport slave (
      input  active_onehot,
      input  led_toggle,
      output hit_pulse,
      output miss_pulse
   );

endinterface

// File: rtl/mole_lfsr.sv
// Seedable 16-bit Galois LFSR that steps only while adv is high.
// Ports: clk, rst_n (async low), adv (step enable), q (current value).
module mole_lfsr
   import mole_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        adv,
   output logic [15:0] q
);

   // An all-zero state would lock up, so a zero seed becomes 1.
   localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] nxt;

   always_comb begin
      nxt = {1'b0, q[15:1]};
      if (q[0]) begin
         nxt = nxt ^ LFSR_TAPS;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= INIT;
      end else if (adv) begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: dark gap, one random mole lit for a window, repeat.
// Ports: clk, rst_n (async low), enable, link (mole_spawner_if.master:
//   active_onehot, led_toggle out; hit_pulse, miss_pulse in),
//   spawn_pulse, mole_idx, hit_count, miss_count (all registered).
// Optional: define MOLE_SPAWNER_SPEEDUP_EN to shrink the window on each hit.
module mole_spawner
   import mole_pkg::*;
#(
   parameter int          N_MOLES           = N_MOLES_DEF,
   parameter int          WINDOW_CYCLES     = 50_000_000,
   parameter int          GAP_CYCLES        = 12_500_000,
   parameter logic [15:0] LFSR_SEED         = 16'hACE1,
   parameter int          MIN_WINDOW_CYCLES = 12_500_000,
   parameter int          WINDOW_STEP       = 2_500_000,
   localparam int         IW                = $clog2(N_MOLES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   mole_spawner_if.master   link,
   output logic             spawn_pulse,
   output logic [IW-1:0]    mole_idx,
   output logic [7:0]       hit_count,
   output logic [7:0]       miss_count
);

   spawn_state_t        state;
   spawn_state_t        state_n;
   logic [31:0]         gap_cnt;
   logic [31:0]         gap_n;
   logic [31:0]         win_cnt;
   logic [31:0]         win_n;
   logic [31:0]         win_load;
   logic [N_MOLES-1:0]  active;
   logic [N_MOLES-1:0]  act_n;
   logic [IW-1:0]       idx_n;
   logic                spawn_n;
   logic [7:0]          hit_n;
   logic [7:0]          miss_n;
   logic                en_q;
   logic                rise;
   logic                hit_take;
   logic [15:0]         lfsr;
   logic [IW-1:0]       raw;
   logic [IW-1:0]       pick;

   mole_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (enable),
      .q     (lfsr)
   );

   assign rise     = enable & ~en_q;
   assign hit_take = enable & (state == SHOW) & link.hit_pulse;

   // Never repeat the previous mole: bump to the next index on a clash.
   always_comb begin
      raw  = IW'(lfsr % 16'(N_MOLES));
      pick = raw;
      if (raw == mole_idx) begin
         pick = (raw == IW'(N_MOLES - 1)) ? '0 : raw + 1'b1;
      end
   end

   // A same-cycle hit suppresses the expiry pulse.
   assign link.led_toggle = (state == SHOW) &&
                            (win_cnt == 32'd1) &&
                            !link.hit_pulse;

   assign link.active_onehot = active;

`ifdef MOLE_SPAWNER_SPEEDUP_EN
   logic [31:0] cur_win;
   logic [31:0] cur_n;

   always_comb begin
      cur_n = cur_win;
      if (rise) begin
         cur_n = 32'(WINDOW_CYCLES);
      end else if (hit_take) begin
         if (cur_win >= 32'(MIN_WINDOW_CYCLES + WINDOW_STEP)) begin
            cur_n = cur_win - 32'(WINDOW_STEP);
         end else begin
            cur_n = 32'(MIN_WINDOW_CYCLES);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_win <= 32'(WINDOW_CYCLES);
      end else begin
         cur_win <= cur_n;
      end
   end

   assign win_load = cur_win;
`else
   logic unused_cfg;

   assign win_load   = 32'(WINDOW_CYCLES);
   assign unused_cfg = ^{MIN_WINDOW_CYCLES, WINDOW_STEP};
`endif

   always_comb begin
      state_n = state;
      gap_n   = gap_cnt;
      win_n   = win_cnt;
      act_n   = active;
      idx_n   = mole_idx;
      spawn_n = 1'b0;
      hit_n   = hit_count;
      miss_n  = miss_count;

      unique case (state)
         IDLE: begin
            if (enable) begin
               state_n = GAP;
               gap_n   = 32'(GAP_CYCLES);
            end
         end
         GAP: begin
            if (gap_cnt <= 32'd1) begin
               state_n = SHOW;
               win_n   = win_load;
               act_n   = N_MOLES'(1) << pick;
               idx_n   = pick;
               spawn_n = 1'b1;
            end else begin
               gap_n = gap_cnt - 32'd1;
            end
         end
         SHOW: begin
            if (link.hit_pulse) begin
               act_n   = '0;
               hit_n   = sat_inc(hit_count);
               state_n = GAP;
               gap_n   = 32'(GAP_CYCLES);
            end else if (win_cnt <= 32'd1) begin
               act_n   = '0;
               state_n = GAP;
               gap_n   = 32'(GAP_CYCLES);
            end else begin
               win_n = win_cnt - 32'd1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (link.miss_pulse) begin
         miss_n = sat_inc(miss_n);
      end

      // Disabled: go dark and freeze the tallies.
      if (!enable) begin
         state_n = IDLE;
         act_n   = '0;
         idx_n   = mole_idx;
         spawn_n = 1'b0;
         hit_n   = hit_count;
         miss_n  = miss_count;
      end

      // A new game starts from zero.
      if (rise) begin
         hit_n  = 8'd0;
         miss_n = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gap_cnt     <= '0;
         win_cnt     <= '0;
         active      <= '0;
         mole_idx    <= '0;
         spawn_pulse <= 1'b0;
         hit_count   <= 8'd0;
         miss_count  <= 8'd0;
         en_q        <= 1'b0;
      end else begin
         state       <= state_n;
         gap_cnt     <= gap_n;
         win_cnt     <= win_n;
         active      <= act_n;
         mole_idx    <= idx_n;
         spawn_pulse <= spawn_n;
         hit_count   <= hit_n;
         miss_count  <= miss_n;
         en_q        <= enable;
      end
   end

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with N_MOLES=10, WINDOW=8, GAP=4.
// Honours MOLE_SPAWNER_SPEEDUP_EN for the shrinking-window expectations.
module tb_mole_spawner;

   localparam int N  = 10;
   localparam int W  = 8;
   localparam int G  = 4;
   localparam int IW = $clog2(N);

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic          spawn_pulse;
   logic [IW-1:0] mole_idx;
   logic [7:0]    hit_count;
   logic [7:0]    miss_count;

   int n_tests;
   int n_fail;

   mole_spawner_if #(.N_MOLES(N)) bus ();

   mole_spawner #(
      .N_MOLES           (N),
      .WINDOW_CYCLES     (W),
      .GAP_CYCLES        (G),
      .LFSR_SEED         (16'hACE1),
      .MIN_WINDOW_CYCLES (4),
      .WINDOW_STEP       (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .link        (bus.master),
      .spawn_pulse (spawn_pulse),
      .mole_idx    (mole_idx),
      .hit_count   (hit_count),
      .miss_count  (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Dark samples from now until a mole lights (bounded).
   task automatic wait_lit(output int dark);
      dark = 0;
      while (bus.active_onehot == '0 && dark < 50) begin
         dark++;
         tick();
      end
   endtask

   // Lit samples from now until dark, with toggle position (bounded).
   task automatic count_lit(output int n, output int tog, output int tog_at);
      n      = 0;
      tog    = 0;
      tog_at = 0;
      while (bus.active_onehot != '0 && n < 50) begin
         n++;
         check("onehot", 32'($onehot(bus.active_onehot)), 32'd1);
         if (bus.led_toggle) begin
            tog++;
            tog_at = n;
         end
         tick();
      end
   endtask

   int         dark;
   int         n;
   int         tog;
   int         tog_at;
   int         win_exp [4];
   logic [IW-1:0] prev;
   logic [N-1:0]  seen;
   logic          done;

   initial begin
`ifdef MOLE_SPAWNER_SPEEDUP_EN
      win_exp = '{8, 6, 4, 4};
`else
      win_exp = '{8, 8, 8, 8};
`endif
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      enable  = 1'b1;
      bus.hit_pulse  = 1'b0;
      bus.miss_pulse = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_led", 32'(bus.active_onehot), 32'd0);
      check("rst_tog", 32'(bus.led_toggle), 32'd0);
      check("rst_spawn", 32'(spawn_pulse), 32'd0);
      check("rst_idx", 32'(mole_idx), 32'd0);
      check("rst_hits", 32'(hit_count), 32'd0);
      check("rst_miss", 32'(miss_count), 32'd0);

      // 1: free-running window; seed ACE1 -> 4th step 1C4E, 7246 % 10 = 6
      @(negedge clk);
      #3;
      rst_n = 1'b1;
      tick();
      wait_lit(dark);
      check("s1_dark", 32'(dark), 32'd4);
      check("s1_spawn", 32'(spawn_pulse), 32'd1);
      check("s1_idx", 32'(mole_idx), 32'd6);
      check("s1_led", 32'(bus.active_onehot), 32'h40);
      tick();
      check("s1_spawn_off", 32'(spawn_pulse), 32'd0);
      count_lit(n, tog, tog_at);
      check("s1_lit", 32'(n + 1), 32'd8);
      check("s1_tog_cnt", 32'(tog), 32'd1);
      check("s1_tog_pos", 32'(tog_at + 1), 32'd8);

      // 2: hit in 3rd lit cycle
      wait_lit(dark);
      check("s2_gap", 32'(dark), 32'd4);
      tick();
      tick();
      check("s2_tog", 32'(bus.led_toggle), 32'd0);
      bus.hit_pulse = 1'b1;
      tick();
      bus.hit_pulse = 1'b0;
      check("s2_dark", 32'(bus.active_onehot), 32'd0);
      check("s2_hits", 32'(hit_count), 32'd1);
      bus.hit_pulse = 1'b1;
      tick();
      bus.hit_pulse = 1'b0;
      check("s2_gap_hit", 32'(hit_count), 32'd1);
      wait_lit(dark);
      check("s2_regap", 32'(dark + 1), 32'd4);

      // 3: hit on the last window cycle
      repeat (7) tick();
      check("s3_tog_pre", 32'(bus.led_toggle), 32'd1);
      bus.hit_pulse = 1'b1;
      #1;
      check("s3_tog_hit", 32'(bus.led_toggle), 32'd0);
      tick();
      bus.hit_pulse = 1'b0;
      check("s3_dark", 32'(bus.active_onehot), 32'd0);
      check("s3_hits", 32'(hit_count), 32'd2);

      // 4: 300 spawns with a miss each
      prev = mole_idx;
      seen = '0;
      for (int s = 0; s < 300; s++) begin
         wait_lit(dark);
         check("s4_gap", 32'(dark), 32'd4);
         check("s4_new", 32'(mole_idx != prev), 32'd1);
         check("s4_onehot", 32'($onehot(bus.active_onehot)), 32'd1);
         prev = mole_idx;
         seen = seen | bus.active_onehot;
         bus.miss_pulse = 1'b1;
         tick();
         bus.miss_pulse = 1'b0;
         count_lit(n, tog, tog_at);
         check("s4_lit", 32'(n + 1), 32'd8);
      end
      check("s4_seen", 32'(seen), 32'h3FF);
      check("s4_miss_sat", 32'(miss_count), 32'd255);

      // 5: reset in 5th lit cycle, then identical replay
      wait_lit(dark);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check("s5_led", 32'(bus.active_onehot), 32'd0);
      check("s5_tog", 32'(bus.led_toggle), 32'd0);
      check("s5_miss", 32'(miss_count), 32'd0);
      check("s5_hits", 32'(hit_count), 32'd0);
      @(negedge clk);
      #3;
      rst_n = 1'b1;
      tick();
      wait_lit(dark);
      check("s5_dark", 32'(dark), 32'd4);
      check("s5_idx", 32'(mole_idx), 32'd6);
      check("s5_led_on", 32'(bus.active_onehot), 32'h40);
      tick();
      count_lit(n, tog, tog_at);
      check("s5_lit", 32'(n + 1), 32'd8);
      check("s5_tog_pos", 32'(tog_at + 1), 32'd8);

      // 6: hits on the last cycle; window shrinks when speedup is built in
      for (int k = 0; k < 4; k++) begin
         wait_lit(dark);
         n    = 0;
         done = 1'b0;
         while (!done && n < 20) begin
            n++;
            if (bus.led_toggle) begin
               bus.hit_pulse = 1'b1;
               #1;
               check("s6_tog_hit", 32'(bus.led_toggle), 32'd0);
               tick();
               bus.hit_pulse = 1'b0;
               done = 1'b1;
            end else begin
               tick();
               if (bus.active_onehot == '0) done = 1'b1;
            end
         end
         check("s6_win", 32'(n), 32'(win_exp[k]));
         check("s6_hits", 32'(hit_count), 32'(k + 1));
      end

      // 7: enable low goes dark, holds tallies; rising enable clears
      wait_lit(dark);
      enable = 1'b0;
      tick();
      check("s7_dark", 32'(bus.active_onehot), 32'd0);
      check("s7_hold", 32'(hit_count), 32'd4);
      tick();
      check("s7_idle", 32'(bus.active_onehot), 32'd0);
      enable = 1'b1;
      tick();
      check("s7_clear", 32'(hit_count), 32'd0);
      wait_lit(dark);
      check("s7_gap", 32'(dark), 32'd4);
      tick();
      count_lit(n, tog, tog_at);
      check("s7_win", 32'(n + 1), 32'd8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mole_spawner.md
# mole_spawner

Drives the whack-a-mole LED field: after a quiet gap it lights one pseudo-randomly chosen mole, holds it for a timed window, and ends the window early on a hit or with a one-cycle timeout pulse. It is the producer side of the mole-detector interface: its `active_onehot` and `led_toggle` feed the detector, and it consumes the detector's `hit_pulse` and `miss_pulse`. It also keeps saturating hit and miss tallies for the score display.

## Interface
- `N_MOLES`, default 10: number of moles/LEDs, range 2..16.
- `WINDOW_CYCLES`, default 50_000_000: mole lit time in cycles, minimum 4.
- `GAP_CYCLES`, default 12_500_000: all-dark time between moles, minimum 1.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.
- `MIN_WINDOW_CYCLES`, default 12_500_000: window floor, used only by the speedup feature.
- `WINDOW_STEP`, default 2_500_000: window decrement per hit, used only by the speedup feature.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  game running; low forces IDLE.
- `hit_pulse`  in  1  from the detector: correct hit.
- `miss_pulse`  in  1  from the detector: window missed.
- `active_onehot`  out  N_MOLES  lit mole, or 0.
- `led_toggle`  out  1  one-cycle pulse marking window expiry.
- `spawn_pulse`  out  1  one-cycle pulse in the first lit cycle.
- `mole_idx`  out  $clog2(N_MOLES)  index of the last spawned mole.
- `hit_count`  out  8  saturating hit tally.
- `miss_count`  out  8  saturating miss tally.

## Operation
- States: IDLE, GAP, SHOW.
- IDLE -> GAP when `enable` is high. Entering GAP loads the gap counter with GAP_CYCLES.
- GAP: the gap counter decrements. When it reaches 0 the block moves to SHOW:
  - selects `idx = lfsr % N_MOLES`;
  - if `idx == mole_idx`, uses `idx+1` instead, wrapping N_MOLES to 0;
  - registers `mole_idx`, sets `active_onehot = 1<<idx`, loads the window counter.
- SHOW: the window counter decrements. Exit conditions, in priority order:
  - `hit_pulse` sampled high: `active_onehot` clears on that edge; `hit_count++`; next state GAP.
  - Last window cycle (counter == 1) and no `hit_pulse`: `led_toggle` is high for that cycle with the mole still lit. `active_onehot` clears at the end of that cycle; next state GAP.
- `miss_pulse` increments `miss_count` in any state. It never changes state.
- `hit_pulse` outside SHOW is ignored.
- Counters saturate at 255 and never wrap.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances every cycle while `enable` is high, so the sequence depends on player timing.
- `enable` low in any state: next edge goes to IDLE, `active_onehot` = 0, tallies hold. Rising `enable` clears both tallies.

## Timing
- Reset values:
  - `active_onehot`, `led_toggle`, `spawn_pulse`, `mole_idx`, tallies: all 0.
  - LFSR: seed value.
  - State: IDLE.
- Reset asserted mid-window clears the LEDs immediately (asynchronous reset).
- Every output is registered, except `led_toggle`. It is decoded from registered state/counter and gated by `hit_pulse`.
- Lit duration is exactly WINDOW_CYCLES cycles, including the `led_toggle` cycle, unless the mole is hit.
- Hit path: `active_onehot` goes to 0 in the cycle after the one in which `hit_pulse` is high. This guarantees the detector is back in IDLE with the LEDs dark, so it cannot re-arm on a stale mole.
- `hit_pulse` in the same cycle as the last window cycle: the hit wins, `led_toggle` stays low, `hit_count` increments.
- Dark time between moles is exactly GAP_CYCLES cycles.

## Configuration
- `MOLE_SPAWNER_SPEEDUP_EN` defined:
  - a registered current-window value starts at WINDOW_CYCLES;
  - each hit reduces it by WINDOW_STEP, clamped at MIN_WINDOW_CYCLES;
  - it resets to WINDOW_CYCLES on reset or on rising `enable`.
- Undefined: the window is fixed at WINDOW_CYCLES; MIN_WINDOW_CYCLES and WINDOW_STEP are unused.

## Structure
- Package `mole_pkg`:
  - state enum `spawn_state_t`;
  - LFSR tap constant;
  - default N_MOLES;
  - `onehot_t` typedef shared with the detector.
- Sub-module `mole_lfsr`: seedable 16-bit Galois LFSR with an advance enable.

## Test plan
All scenarios use N_MOLES=10, WINDOW_CYCLES=8, GAP_CYCLES=4.
1. Reset release with `enable` high, no hits: 4 dark cycles, then one LED lit for 8 cycles. `led_toggle` is high in the 8th lit cycle; LEDs are dark on the next cycle.
2. `hit_pulse` in the 3rd lit cycle: LEDs are 0 on the next cycle, `hit_count`=1, `led_toggle` never asserts, the next mole lights 4 cycles later.
3. `hit_pulse` coincident with the 8th lit cycle: `led_toggle` stays 0, `hit_count`=1.
4. 300 consecutive spawns:
   - no two consecutive spawns share `mole_idx`;
   - `active_onehot` is always 0 or exactly one-hot;
   - every index 0..9 appears at least once;
   - 300 `miss_pulse` inputs leave `miss_count` = 255.
5. `rst_n` low in the 5th lit cycle: LEDs 0 asynchronously; after release, behaviour matches scenario 1 with an identical LFSR sequence.
6. With `MOLE_SPAWNER_SPEEDUP_EN` defined (WINDOW_STEP=2, MIN_WINDOW_CYCLES=4): consecutive hits give windows of 8, 6, 4, 4 cycles.
